// File: rtl/multi_bay_weapons_controller.sv
// Weapons control unit: round-robin multi-bay salvo launcher with inter-launch
// cooldown, per-bay/total ammunition tracking and a sequenced reload.
module multi_bay_weapons_controller #(
   parameter  int NUM_BAYS         = 4,
   parameter  int MISSILES_PER_BAY = 4,
   parameter  int COOLDOWN_CYCLES  = 3,
   parameter  int SALVO_W          = 3,
   localparam int BAY_W            = $clog2(NUM_BAYS),
   localparam int TOT_W            = $clog2(NUM_BAYS*MISSILES_PER_BAY+1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                target_locked,
   input  logic                fire_command,
   input  logic [SALVO_W-1:0]  salvo_size,
   input  logic                reload_req,
   output logic                launch_missile,
   output logic [BAY_W-1:0]    launch_bay,
   output logic [TOT_W-1:0]    remaining_missiles,
   output logic [NUM_BAYS-1:0] bay_empty,
   output logic [2:0]          WCU_state
);

   localparam int CNT_W = $clog2(MISSILES_PER_BAY+1);
   localparam int CD_W  = $clog2(COOLDOWN_CYCLES+1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      LOCKED      = 3'd1,
      FIRE        = 3'd2,
      COOLDOWN    = 3'd3,
      OUT_OF_AMMO = 3'd4,
      RELOAD      = 3'd5
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    bay_cnt   [NUM_BAYS];
   logic [CNT_W-1:0]    bay_cnt_d [NUM_BAYS];
   logic [TOT_W-1:0]    remaining_d;
   logic [NUM_BAYS-1:0] bay_empty_d;
   logic                launch_d;
   logic [BAY_W-1:0]    launch_bay_d;
   logic [BAY_W-1:0]    ptr, ptr_d;
   logic [BAY_W-1:0]    reload_idx, reload_idx_d;
   logic [BAY_W-1:0]    sel;
   logic                sel_found;
   logic [SALVO_W-1:0]  salvo_left, salvo_left_d;
   logic [CD_W-1:0]     cd_cnt, cd_cnt_d;
   logic                fire_q;
   logic                fire_req;
   logic                do_launch;

   // Rounds for a new salvo: at least one, never more than are left on board.
   function automatic logic [SALVO_W-1:0] sat_salvo(input logic [SALVO_W-1:0] req,
                                                    input logic [TOT_W-1:0]   avail);
      int r;
      r = (req == '0) ? 1 : int'(req);
      if (r > int'(avail)) r = int'(avail);
      return SALVO_W'(r);
   endfunction

   assign fire_req  = fire_command & ~fire_q;
   assign WCU_state = state;

   // First non-empty bay at or after ptr; the reverse scan lets the nearest win.
   always_comb begin
      int idx;
      idx       = 0;
      sel       = ptr;
      sel_found = 1'b0;
      for (int j = NUM_BAYS-1; j >= 0; j--) begin
         idx = (int'(ptr) + j) % NUM_BAYS;
         if (bay_cnt[idx] != '0) begin
            sel       = BAY_W'(idx);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state;
      bay_cnt_d    = bay_cnt;
      ptr_d        = ptr;
      salvo_left_d = salvo_left;
      cd_cnt_d     = cd_cnt;
      reload_idx_d = reload_idx;
      launch_d     = 1'b0;
      launch_bay_d = launch_bay;
      do_launch    = 1'b0;

      case (state)
         IDLE: begin
            if (reload_req) begin
               state_d      = RELOAD;
               reload_idx_d = '0;
            end else if (target_locked) begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (!target_locked) begin
               state_d = IDLE;
            end else if (fire_req && sel_found) begin
               salvo_left_d = sat_salvo(salvo_size, remaining_missiles);
               do_launch    = 1'b1;
            end
         end
         FIRE: begin
            state_d  = COOLDOWN;
            cd_cnt_d = '0;
         end
         COOLDOWN: begin
            if (cd_cnt == CD_W'(COOLDOWN_CYCLES-1)) begin
               cd_cnt_d = '0;
               if (remaining_missiles == '0) begin
                  state_d      = OUT_OF_AMMO;
                  salvo_left_d = '0;
               end else if (!target_locked) begin
                  state_d      = IDLE;
                  salvo_left_d = '0;
               end else if (salvo_left != '0 && sel_found) begin
                  do_launch = 1'b1;
               end else begin
                  state_d = LOCKED;
               end
            end else begin
               cd_cnt_d = cd_cnt + 1'b1;
            end
         end
         OUT_OF_AMMO: begin
            if (reload_req) begin
               state_d      = RELOAD;
               reload_idx_d = '0;
            end
         end
         RELOAD: begin
            for (int i = 0; i < NUM_BAYS; i++) begin
               if (BAY_W'(i) == reload_idx) bay_cnt_d[i] = CNT_W'(MISSILES_PER_BAY);
            end
            ptr_d = '0;
            if (reload_idx == BAY_W'(NUM_BAYS-1)) state_d = IDLE;
            else reload_idx_d = reload_idx + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (do_launch) begin
         state_d        = FIRE;
         launch_d       = 1'b1;
         launch_bay_d   = sel;
         bay_cnt_d[sel] = bay_cnt[sel] - 1'b1;
         ptr_d          = (sel == BAY_W'(NUM_BAYS-1)) ? '0 : sel + 1'b1;
         salvo_left_d   = salvo_left_d - 1'b1;
      end
   end

   // Totals follow the next bay contents so they change on the same edge.
   always_comb begin
      remaining_d = '0;
      bay_empty_d = '0;
      for (int i = 0; i < NUM_BAYS; i++) begin
         remaining_d    = remaining_d + TOT_W'(bay_cnt_d[i]);
         bay_empty_d[i] = (bay_cnt_d[i] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         for (int i = 0; i < NUM_BAYS; i++) bay_cnt[i] <= CNT_W'(MISSILES_PER_BAY);
         remaining_missiles <= TOT_W'(NUM_BAYS*MISSILES_PER_BAY);
         bay_empty          <= '0;
         launch_missile     <= 1'b0;
         launch_bay         <= '0;
         ptr                <= '0;
         reload_idx         <= '0;
         salvo_left         <= '0;
         cd_cnt             <= '0;
         fire_q             <= 1'b0;
      end else begin
         state              <= state_d;
         bay_cnt            <= bay_cnt_d;
         remaining_missiles <= remaining_d;
         bay_empty          <= bay_empty_d;
         launch_missile     <= launch_d;
         launch_bay         <= launch_bay_d;
         ptr                <= ptr_d;
         reload_idx         <= reload_idx_d;
         salvo_left         <= salvo_left_d;
         cd_cnt             <= cd_cnt_d;
         fire_q             <= fire_command;
      end
   end

endmodule

// File: tb/tb_multi_bay_weapons_controller.sv
// Bench for multi_bay_weapons_controller: directed scenarios, a behavioural
// ammunition/salvo model compared every cycle, plus literal expectations.
module tb_multi_bay_weapons_controller;

   localparam int N   = 4;
   localparam int MPB = 4;
   localparam int C   = 3;

   localparam int S_IDLE = 0, S_LOCKED = 1, S_FIRE = 2, S_COOL = 3, S_OOA = 4, S_RELOAD = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       target_locked = 1'b0;
   logic       fire_command = 1'b0;
   logic [2:0] salvo_size = 3'd0;
   logic       reload_req = 1'b0;
   logic       launch_missile;
   logic [1:0] launch_bay;
   logic [4:0] remaining_missiles;
   logic [3:0] bay_empty;
   logic [2:0] WCU_state;

   multi_bay_weapons_controller #(
      .NUM_BAYS(N), .MISSILES_PER_BAY(MPB), .COOLDOWN_CYCLES(C), .SALVO_W(3)
   ) dut (
      .clk(clk), .rst(rst), .target_locked(target_locked), .fire_command(fire_command),
      .salvo_size(salvo_size), .reload_req(reload_req), .launch_missile(launch_missile),
      .launch_bay(launch_bay), .remaining_missiles(remaining_missiles),
      .bay_empty(bay_empty), .WCU_state(WCU_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lb_q[$];
   int lc_q[$];
   int n0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_state = S_IDLE;
   int m_bays[N] = '{MPB, MPB, MPB, MPB};
   int m_ptr = 0, m_salvo = 0, m_timer = 0, m_ri = 0, m_bay_out = 0;
   int m_prev_fire = 0;
   int m_launch = 0;
   int m_fr;

   function automatic int m_total();
      int s = 0;
      for (int i = 0; i < N; i++) s += m_bays[i];
      return s;
   endfunction

   function automatic int m_empty();
      int e = 0;
      for (int i = 0; i < N; i++) if (m_bays[i] == 0) e |= (1 << i);
      return e;
   endfunction

   task m_shoot();
      int b;
      bit done;
      done = 0;
      for (int j = 0; j < N; j++) begin
         b = (m_ptr + j) % N;
         if (!done && m_bays[b] > 0) begin
            m_bays[b]--;
            m_bay_out = b;
            m_ptr     = (b + 1) % N;
            m_salvo--;
            m_launch  = 1;
            done      = 1;
         end
      end
   endtask

   task m_step();
      m_fr        = (fire_command && !m_prev_fire) ? 1 : 0;
      m_prev_fire = fire_command ? 1 : 0;
      m_launch    = 0;
      case (m_state)
         S_IDLE: begin
            if (reload_req) begin m_state = S_RELOAD; m_ri = 0; end
            else if (target_locked) m_state = S_LOCKED;
         end
         S_LOCKED: begin
            if (!target_locked) m_state = S_IDLE;
            else if (m_fr != 0 && m_total() > 0) begin
               m_salvo = (salvo_size == 0) ? 1 : int'(salvo_size);
               if (m_salvo > m_total()) m_salvo = m_total();
               m_shoot();
               m_state = S_FIRE;
            end
         end
         S_FIRE: begin m_state = S_COOL; m_timer = C; end
         S_COOL: begin
            m_timer--;
            if (m_timer == 0) begin
               if (m_total() == 0) begin m_state = S_OOA; m_salvo = 0; end
               else if (!target_locked) begin m_state = S_IDLE; m_salvo = 0; end
               else if (m_salvo > 0) begin m_shoot(); m_state = S_FIRE; end
               else m_state = S_LOCKED;
            end
         end
         S_OOA: if (reload_req) begin m_state = S_RELOAD; m_ri = 0; end
         S_RELOAD: begin
            m_bays[m_ri] = MPB;
            m_ptr = 0;
            m_ri++;
            if (m_ri == N) m_state = S_IDLE;
         end
         default: m_state = S_IDLE;
      endcase
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_state = S_IDLE; m_ptr = 0; m_salvo = 0; m_timer = 0; m_ri = 0;
         m_bay_out = 0; m_prev_fire = 0; m_launch = 0;
         for (int i = 0; i < N; i++) m_bays[i] = MPB;
      end else begin
         m_step();
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- per-cycle compare ----------------
   int prev_launch = 0;
   initial forever begin
      @(negedge clk);
      chk("launch_missile", int'(launch_missile), m_launch);
      if (m_launch != 0) chk("launch_bay", int'(launch_bay), m_bay_out);
      chk("remaining", int'(remaining_missiles), m_total());
      chk("bay_empty", int'(bay_empty), m_empty());
      chk("state", int'(WCU_state), m_state);
      chk("pulse_width", (launch_missile && prev_launch != 0) ? 1 : 0, 0);
      prev_launch = launch_missile ? 1 : 0;
      if (launch_missile) begin
         lb_q.push_back(int'(launch_bay));
         lc_q.push_back(cyc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_state(input int s, input int lim);
      int n = 0;
      while (int'(WCU_state) != s && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("wait_state", int'(WCU_state), s);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0; target_locked = 1'b0; fire_command = 1'b0;
      reload_req = 1'b0; salvo_size = 3'd0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   int exp_e[4] = '{14, 12, 8, 0};

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_state", int'(WCU_state), 0);
      chk("rst_remaining", int'(remaining_missiles), 16);
      chk("rst_empty", int'(bay_empty), 0);
      chk("rst_launch", int'(launch_missile), 0);
      chk("rst_bay", int'(launch_bay), 0);
      #2 rst = 1'b1;

      // single shot
      @(negedge clk); target_locked = 1'b1;
      @(negedge clk); chk("lock_state", int'(WCU_state), S_LOCKED);
      salvo_size = 3'd1; fire_command = 1'b1; n0 = lb_q.size();
      @(negedge clk);
      chk("single_launch", int'(launch_missile), 1);
      chk("single_bay", int'(launch_bay), 0);
      chk("single_remaining", int'(remaining_missiles), 15);
      @(negedge clk);
      chk("single_pulse_end", int'(launch_missile), 0);
      chk("single_cooldown", int'(WCU_state), S_COOL);
      repeat (2) @(negedge clk);
      chk("single_cooldown_held", int'(WCU_state), S_COOL);
      @(negedge clk);
      chk("single_locked", int'(WCU_state), S_LOCKED);
      repeat (10) @(negedge clk);
      chk("hold_no_refire", lb_q.size() - n0, 1);
      fire_command = 1'b0;

      // salvo of three from fresh reset
      do_reset();
      target_locked = 1'b1;
      @(negedge clk);
      salvo_size = 3'd3; n0 = lb_q.size(); fire_command = 1'b1;
      @(negedge clk);
      wait_state(S_LOCKED, 40);
      chk("s3_count", lb_q.size() - n0, 3);
      chk("s3_bay0", lb_q[n0], 0);
      chk("s3_bay1", lb_q[n0+1], 1);
      chk("s3_bay2", lb_q[n0+2], 2);
      chk("s3_spacing1", lc_q[n0+1] - lc_q[n0], 4);
      chk("s3_spacing2", lc_q[n0+2] - lc_q[n0+1], 4);
      chk("s3_duration", cyc - lc_q[n0], 12);
      chk("s3_remaining", int'(remaining_missiles), 13);
      fire_command = 1'b0;
      @(negedge clk);
      salvo_size = 3'd1; n0 = lb_q.size(); fire_command = 1'b1;
      @(negedge clk);
      wait_state(S_LOCKED, 20);
      chk("s3_next_bay", lb_q[n0], 3);
      chk("s3_next_remaining", int'(remaining_missiles), 12);
      fire_command = 1'b0;

      // abort mid-salvo
      do_reset();
      target_locked = 1'b1;
      @(negedge clk);
      salvo_size = 3'd4; n0 = lb_q.size(); fire_command = 1'b1;
      @(negedge clk);
      repeat (4) @(negedge clk);
      chk("abort_second_launch", int'(launch_missile), 1);
      @(negedge clk);
      target_locked = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_cooldown_full", int'(WCU_state), S_COOL);
      @(negedge clk);
      chk("abort_idle", int'(WCU_state), S_IDLE);
      fire_command = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort_count", lb_q.size() - n0, 2);
      chk("abort_remaining", int'(remaining_missiles), 14);

      // depletion and reload
      do_reset();
      target_locked = 1'b1;
      @(negedge clk);
      n0 = lb_q.size();
      for (int s = 0; s < 3; s++) begin
         salvo_size = 3'd7; fire_command = 1'b1;
         @(negedge clk);
         wait_state((s < 2) ? S_LOCKED : S_OOA, 60);
         fire_command = 1'b0;
         @(negedge clk);
      end
      chk("dep_count", lb_q.size() - n0, 16);
      chk("dep_last_bay_a", lb_q[lb_q.size()-2], 2);
      chk("dep_last_bay_b", lb_q[lb_q.size()-1], 3);
      chk("dep_empty", int'(bay_empty), 15);
      chk("dep_remaining", int'(remaining_missiles), 0);
      n0 = lb_q.size();
      fire_command = 1'b1;
      repeat (3) @(negedge clk);
      chk("ooa_ignores_fire", int'(WCU_state), S_OOA);
      chk("ooa_no_launch", lb_q.size() - n0, 0);
      fire_command = 1'b0;
      reload_req = 1'b1;
      @(negedge clk);
      chk("reload_enter", int'(WCU_state), S_RELOAD);
      chk("reload_empty_start", int'(bay_empty), 15);
      reload_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("reload_empty_step", int'(bay_empty), exp_e[i]);
         chk("reload_state_step", int'(WCU_state), (i < 3) ? S_RELOAD : S_IDLE);
      end
      chk("reload_remaining", int'(remaining_missiles), 16);

      // reset in the middle of a salvo
      do_reset();
      target_locked = 1'b1;
      @(negedge clk);
      salvo_size = 3'd3; n0 = lb_q.size(); fire_command = 1'b1;
      @(negedge clk);
      repeat (2) @(negedge clk);
      chk("midrst_in_cooldown", int'(WCU_state), S_COOL);
      #2 rst = 1'b0;
      #1;
      chk("midrst_state", int'(WCU_state), 0);
      chk("midrst_remaining", int'(remaining_missiles), 16);
      chk("midrst_launch", int'(launch_missile), 0);
      chk("midrst_empty", int'(bay_empty), 0);
      fire_command = 1'b0; target_locked = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("midrst_no_more_launch", lb_q.size() - n0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/multi_bay_weapons_controller.md
# multi_bay_weapons_controller

Parametrised weapons control unit for the UCAV payload subsystem. It manages NUM_BAYS independent missile bays, fires multi-round salvos with a mandatory inter-launch cooldown, and selects bays round-robin. It tracks per-bay and total ammunition and supports a sequenced reload. It sits between the targeting/lock logic and the launcher drivers.

## Interface
- NUM_BAYS, 4: number of missile bays (≥2).
- MISSILES_PER_BAY, 4: capacity of each bay (≥1).
- COOLDOWN_CYCLES, 3: idle cycles after every launch (≥1).
- SALVO_W, 3: width of salvo_size.
- Derived: BAY_W = $clog2(NUM_BAYS); TOT_W = $clog2(NUM_BAYS*MISSILES_PER_BAY+1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- target_locked  in  1  level; target currently locked.
- fire_command  in  1  fire request; only the rising edge is used.
- salvo_size  in  SALVO_W  rounds per salvo; latched at salvo start.
- reload_req  in  1  level; request rearming.
- launch_missile  out  1  one-cycle launch pulse per round.
- launch_bay  out  BAY_W  bay fired; valid while launch_missile=1.
- remaining_missiles  out  TOT_W  total rounds across all bays.
- bay_empty  out  NUM_BAYS  bit i=1 when bay i holds 0 rounds.
- WCU_state  out  3  IDLE=0, LOCKED=1, FIRE=2, COOLDOWN=3, OUT_OF_AMMO=4, RELOAD=5.

## Operation
- All outputs are registered. No logic is clocked by any signal other than clk and rst.
- Fire edge detection: fire_req = fire_command & ~fire_q. fire_q is a register that resets to 0. A fire_req arriving in any state other than LOCKED is discarded.
- IDLE:
  - reload_req=1 → RELOAD. This has priority.
  - Otherwise target_locked=1 → LOCKED.
- LOCKED:
  - target_locked=0 → IDLE.
  - Otherwise fire_req → FIRE. salvo_left = max(salvo_size,1), clamped to remaining_missiles.
- Launch (on the edge entering FIRE):
  - launch_missile is set to 1.
  - The selected bay is decremented and written to launch_bay.
  - salvo_left is decremented.
- Bay selection: the first non-empty bay searching ptr, ptr+1, … with wrap modulo NUM_BAYS. Then ptr = selected+1 mod NUM_BAYS.
- FIRE: always lasts exactly 1 cycle, then → COOLDOWN. launch_missile is cleared on that edge.
- COOLDOWN: lasts exactly COOLDOWN_CYCLES cycles. The exit is decided at the final edge, in priority order:
  1. remaining=0 → OUT_OF_AMMO.
  2. target_locked=0 → IDLE, and salvo_left is cleared (abort).
  3. salvo_left>0 → FIRE, which launches the next round.
  4. Otherwise → LOCKED.
- Target loss during COOLDOWN does not shorten the cooldown.
- OUT_OF_AMMO: held until reload_req=1 → RELOAD. fire_command and target_locked are ignored.
- RELOAD: lasts NUM_BAYS cycles. Bay i is set to MISSILES_PER_BAY at the i-th edge in RELOAD, and its bay_empty bit clears at the same edge. ptr is reset to 0. Then → IDLE unconditionally.
- reload_req is ignored in LOCKED, FIRE and COOLDOWN.
- remaining_missiles always equals the sum of the bay counters. It is updated on the same edge as the bay change.
- Arithmetic: counters never go below 0 and never exceed MISSILES_PER_BAY. A launch never selects an empty bay, which the clamp guarantees.

## Timing
- Reset values:
  - State: IDLE.
  - Every bay: MISSILES_PER_BAY.
  - remaining_missiles: NUM_BAYS*MISSILES_PER_BAY.
  - Other outputs: launch_missile=0, launch_bay=0, bay_empty=0.
  - Internal registers: ptr=0, salvo_left=0, cooldown counter=0, fire_q=0.
- Reset applies immediately on assertion, including mid-salvo, and cancels any pending rounds.
- Latency from lock: target_locked high at edge k while IDLE → LOCKED after edge k.
- Latency to first launch: fire_req sampled at edge k while LOCKED → launch_missile=1 during cycle k..k+1.
- Launch spacing: rounds in a salvo are spaced COOLDOWN_CYCLES+1 cycles apart.
- Launch pulse width: launch_missile is high for exactly 1 cycle per round, never 2 consecutive cycles.
- Salvo duration: S rounds take S*(COOLDOWN_CYCLES+1) cycles from the first launch until LOCKED, IDLE or OUT_OF_AMMO.
- Re-firing: holding fire_command high does not re-fire. A new rising edge is required.

## Test plan
All scenarios use NUM_BAYS=4, MISSILES_PER_BAY=4, COOLDOWN_CYCLES=3.
- Reset: drive rst=0 asynchronously → WCU_state=0, remaining=16, bay_empty=0000, launch_missile=0.
- Single shot: lock, then fire edge with salvo_size=1:
  - launch_missile=1 for 1 cycle, launch_bay=0, remaining=15.
  - COOLDOWN for 3 cycles, then LOCKED.
  - fire_command held high → no further launches.
- Salvo of 3 from fresh reset:
  - Launches on bays 0, 1, 2, four cycles apart.
  - remaining=13, then LOCKED.
  - Next single shot uses bay 3.
- Abort: salvo_size=4, drop target_locked in the cooldown after the 2nd launch:
  - No 3rd launch.
  - Cooldown completes its 3 cycles, then IDLE.
  - remaining=14.
- Depletion:
  - Fire 14 rounds, then a salvo with salvo_size=7 → only 2 launches, bay_empty=1111, then OUT_OF_AMMO.
  - A fire edge in OUT_OF_AMMO is ignored.
  - reload_req → RELOAD for 4 cycles, bay_empty clears one bit per cycle, remaining=16, then IDLE.
- Reset mid-salvo: assert rst during COOLDOWN of a 3-round salvo → immediate IDLE, remaining=16, no further launch_missile pulses.
